// File: rtl/fp_seq_pkg.sv
// Shared types, constants and helpers for the fp_addsub_seq sequencer.
// FP_RNE_ROUND_EN widens the datapath with guard/round/sticky bits and adds a ROUND state.
package fp_seq_pkg;

    localparam int EXP_W  = 3;
    localparam int MANT_W = 4;
    localparam int BIAS   = 3;

    localparam logic [EXP_W-1:0]  EXP_MAX   = {EXP_W{1'b1}};
    localparam logic [MANT_W-1:0] MANT_ONES = {MANT_W{1'b1}};

`ifdef FP_RNE_ROUND_EN
    localparam int GRS_W = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4,
        S_ROUND = 3'd5
    } state_t;
`else
    localparam int GRS_W = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`endif

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_t;

    // A zero exponent field encodes zero regardless of the mantissa.
    function automatic logic is_zero(input logic [15:0] exp_field);
        return exp_field == 16'd0;
    endfunction

endpackage

// File: rtl/fp_addsub_seq_exp_compare.sv
// Exponent comparator: picks the larger exponent (A on a tie) and the shift distance.
module exp_compare #(
    parameter int EXP_W = 3
) (
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    output logic [EXP_W-1:0] diff_mag,
    output logic             a_bigger,
    output logic [EXP_W-1:0] exp_big
);

    logic [EXP_W:0] diff_s;

    // The borrow of eA - eB tells which exponent is larger.
    always_comb begin
        diff_s   = {1'b0, exp_a} - {1'b0, exp_b};
        a_bigger = ~diff_s[EXP_W];
        if (a_bigger) begin
            diff_mag = diff_s[EXP_W-1:0];
            exp_big  = exp_a;
        end else begin
            diff_mag = exp_b - exp_a;
            exp_big  = exp_b;
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle small-format floating-point add/subtract: align, add, normalise one step per cycle.
// Optional macro FP_RNE_ROUND_EN selects round-to-nearest-even; the default build truncates.
module fp_addsub_seq #(
    parameter int EXP_W  = 3,
    parameter int MANT_W = 4,
    parameter int BIAS   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+MANT_W:0]     op_a,
    input  logic [EXP_W+MANT_W:0]     op_b,
    input  logic                      op_sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     result,
    output logic                      ovf,
    output logic                      unf,
    output logic                      busy
);
    import fp_seq_pkg::*;

    localparam int DW = 1 + EXP_W + MANT_W;
    localparam int SW = MANT_W + 1 + GRS_W;
    localparam int MW = SW + 1;
    localparam int FW = MANT_W + GRS_W;
    localparam int CW = EXP_W + 1;
    localparam logic [CW-1:0]     CNT_SAT = CW'(MANT_W + 2);
    localparam logic [EXP_W-1:0]  E_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]  E_ONE   = EXP_W'(1'b1);
    localparam logic [MANT_W-1:0] M_ONES  = {MANT_W{1'b1}};

    state_t            state_q, state_d;
    logic [MW-1:0]     mant_q, mant_d;
    logic [SW-1:0]     sml_q, sml_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sgn_q, sgn_d;
    logic              sgn_sml_q, sgn_sml_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [EXP_W-1:0]  ea_s, eb_s, diff_mag_s, exp_big_s;
    logic [MANT_W-1:0] ma_s, mb_s;
    logic              sa_s, sb_s, za_s, zb_s, a_bigger_s;
    logic [MW-1:0]     sml_ext_s, sum_s, mant_shr_s, mant_shl_s;
    logic [SW-1:0]     sml_shr_s;
    logic              sum_sgn_s;
    logic              fin_s;
    logic [FW-1:0]     fin_v_s;
    logic [EXP_W-1:0]  fin_e_s;
`ifdef FP_RNE_ROUND_EN
    logic [MANT_W+1:0] rnd_s;
    logic              up_s;
`endif

    assign sa_s = op_a[DW-1];
    assign sb_s = op_b[DW-1] ^ op_sub;
    assign ea_s = op_a[DW-2 -: EXP_W];
    assign eb_s = op_b[DW-2 -: EXP_W];
    assign ma_s = op_a[MANT_W-1:0];
    assign mb_s = op_b[MANT_W-1:0];
    assign za_s = is_zero(16'(ea_s));
    assign zb_s = is_zero(16'(eb_s));

    exp_compare #(.EXP_W(EXP_W)) u_exp_compare (
        .exp_a    (ea_s),
        .exp_b    (eb_s),
        .diff_mag (diff_mag_s),
        .a_bigger (a_bigger_s),
        .exp_big  (exp_big_s)
    );

    // Shared datapath: signed-magnitude add/subtract and the one-bit shifters.
    always_comb begin
        sml_ext_s = {1'b0, sml_q};
        if (sgn_q == sgn_sml_q) begin
            sum_s     = mant_q + sml_ext_s;
            sum_sgn_s = sgn_q;
        end else if (mant_q >= sml_ext_s) begin
            sum_s     = mant_q - sml_ext_s;
            sum_sgn_s = sgn_q;
        end else begin
            sum_s     = sml_ext_s - mant_q;
            sum_sgn_s = sgn_sml_q;
        end
`ifdef FP_RNE_ROUND_EN
        sml_shr_s  = {1'b0, sml_q[SW-1:2], |sml_q[1:0]};
        mant_shr_s = {1'b0, mant_q[SW:2], |mant_q[1:0]};
        up_s       = mant_q[GRS_W-1] & ((|mant_q[GRS_W-2:0]) | mant_q[GRS_W]);
        rnd_s      = {1'b0, mant_q[SW-1:GRS_W]} + {{(MANT_W+1){1'b0}}, up_s};
`else
        sml_shr_s  = {1'b0, sml_q[SW-1:1]};
        mant_shr_s = {1'b0, mant_q[SW:1]};
`endif
        mant_shl_s = {mant_q[SW-1:0], 1'b0};
    end

    // State register and datapath flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mant_q    <= {MW{1'b0}};
            sml_q     <= {SW{1'b0}};
            exp_q     <= {EXP_W{1'b0}};
            sgn_q     <= 1'b0;
            sgn_sml_q <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            result_q  <= {DW{1'b0}};
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mant_q    <= mant_d;
            sml_q     <= sml_d;
            exp_q     <= exp_d;
            sgn_q     <= sgn_d;
            sgn_sml_q <= sgn_sml_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Next-state and datapath update; fin_s marks a normalised value ready to pack.
    always_comb begin
        state_d   = state_q;
        mant_d    = mant_q;
        sml_d     = sml_q;
        exp_d     = exp_q;
        sgn_d     = sgn_q;
        sgn_sml_d = sgn_sml_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        fin_s     = 1'b0;
        fin_v_s   = mant_q[FW-1:0];
        fin_e_s   = exp_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    if (za_s && zb_s) begin
                        result_d = {DW{1'b0}};
                        state_d  = S_DONE;
                    end else if (za_s) begin
                        result_d = {sb_s, eb_s, mb_s};
                        state_d  = S_DONE;
                    end else if (zb_s) begin
                        result_d = {sa_s, ea_s, ma_s};
                        state_d  = S_DONE;
                    end else begin
                        exp_d     = exp_big_s;
                        sgn_d     = a_bigger_s ? sa_s : sb_s;
                        sgn_sml_d = a_bigger_s ? sb_s : sa_s;
                        mant_d    = MW'({2'b01, (a_bigger_s ? ma_s : mb_s)}) << GRS_W;
                        sml_d     = SW'({1'b1, (a_bigger_s ? mb_s : ma_s)}) << GRS_W;
                        if (diff_mag_s != {EXP_W{1'b0}}) begin
                            cnt_d   = (CW'(diff_mag_s) > CNT_SAT) ? CNT_SAT : CW'(diff_mag_s);
                            state_d = S_ALIGN;
                        end else begin
                            state_d = S_ADD;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ALIGN: begin
                sml_d = sml_shr_s;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1'b1)) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_ALIGN;
                end
            end
            S_ADD: begin
                sgn_d = sum_sgn_s;
                if (sum_s == {MW{1'b0}}) begin
                    result_d = {DW{1'b0}};
                    state_d  = S_DONE;
                end else if (sum_s[SW] || !sum_s[SW-1]) begin
                    mant_d  = sum_s;
                    state_d = S_NORM;
                end else begin
                    fin_s   = 1'b1;
                    fin_v_s = sum_s[FW-1:0];
                end
            end
            S_NORM: begin
                if (mant_q[SW]) begin
                    if (exp_q == E_ONES) begin
                        ovf_d    = 1'b1;
                        result_d = {sgn_q, E_ONES, M_ONES};
                        state_d  = S_DONE;
                    end else begin
                        fin_s   = 1'b1;
                        fin_v_s = mant_shr_s[FW-1:0];
                        fin_e_s = exp_q + E_ONE;
                    end
                end else if (mant_q[SW-1]) begin
                    fin_s = 1'b1;
                end else if (exp_q == E_ONE) begin
                    // Another left shift would need exponent 0, which encodes zero.
                    unf_d    = 1'b1;
                    result_d = {DW{1'b0}};
                    state_d  = S_DONE;
                end else begin
                    mant_d = mant_shl_s;
                    exp_d  = exp_q - E_ONE;
                    if (mant_shl_s[SW-1]) begin
                        fin_s   = 1'b1;
                        fin_v_s = mant_shl_s[FW-1:0];
                        fin_e_s = exp_q - E_ONE;
                    end else begin
                        state_d = S_NORM;
                    end
                end
            end
`ifdef FP_RNE_ROUND_EN
            S_ROUND: begin
                if (rnd_s[MANT_W+1]) begin
                    mant_d  = {rnd_s, {GRS_W{1'b0}}};
                    state_d = S_NORM;
                end else begin
                    result_d = {sgn_q, exp_q, rnd_s[MANT_W-1:0]};
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        case (fin_s)
            1'b1: begin
`ifdef FP_RNE_ROUND_EN
                mant_d  = {2'b01, fin_v_s};
                exp_d   = fin_e_s;
                state_d = S_ROUND;
`else
                result_d = {sgn_d, fin_e_s, fin_v_s};
                state_d  = S_DONE;
`endif
            end
            default: begin
                fin_e_s = fin_e_s;
            end
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign result = result_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Multi-cycle sequencer for a small-format floating-point add/subtract.
- Accepts two operands over a valid/ready handshake, then works through the operation one step per cycle: compare exponents, align the smaller mantissa, add or subtract, normalise.
- Returns the packed result and status flags over a second valid/ready handshake.
- Sits between the operand source (register file or test driver) and the result consumer; the datapath is reused across cycles instead of being fully combinational.

Parameters:
- EXP_W, 3, exponent field width.
- MANT_W, 4, stored mantissa width (hidden leading 1 not stored).
- BIAS, 3, exponent bias.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- op_a  in  1+EXP_W+MANT_W  operand A, packed {s, e, m}.
- op_b  in  1+EXP_W+MANT_W  operand B.
- op_sub  in  1  0 = A+B, 1 = A−B (inverts B sign at accept).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- result  out  1+EXP_W+MANT_W  packed result.
- ovf  out  1  exponent overflow, result saturated.
- unf  out  1  underflow, result flushed to zero.
- busy  out  1  state != IDLE.

Behaviour:
- Encoding: e==0 means zero (mantissa ignored). Otherwise value = (−1)^s × 1.m × 2^(e−BIAS). No denormals, no inf/NaN. Rounding is truncation.
- Reset (rst_n low at clk edge, from any state, including mid-operation):
  - state = IDLE.
  - in_ready = 1.
  - out_valid, result, ovf, unf, busy = 0.
  - In-flight operation is discarded.
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready = 1. On in_valid & in_ready, latch operands (B sign ^ op_sub).
  - Compute diff = eA − eB in EXP_W+1 bits. The borrow bit selects the bigger exponent; on a tie, A is bigger.
  - If either operand is zero, go to DONE with result = the other operand (signed). If both are zero, result = +0.
  - Else if |diff| > 0, go to ALIGN with cnt = min(|diff|, MANT_W+2). Else go to ADD.
- ALIGN:
  - Shift the smaller mantissa (MANT_W+1 bits including hidden bit) right by 1 each cycle and decrement cnt.
  - Go to ADD when cnt reaches 1 (after the last shift).
  - The cnt saturation guarantees the mantissa becomes 0 for large differences.
- ADD:
  - Same effective signs: sum = mA + mB (MANT_W+2 bits).
  - Different signs: subtract the smaller magnitude from the larger. On equal exponents, compare mantissas; if still equal, the result is +0.
  - Result sign = sign of the larger magnitude.
  - Sum == 0: go to DONE with +0. Else, if the carry bit is set or the hidden bit is clear, go to NORM; otherwise go to DONE.
- NORM, one shift per cycle:
  - Carry set: shift right 1, exp + 1. If exp would exceed 2^EXP_W−1, set ovf and result = {s, all-ones e, all-ones m}, then go to DONE.
  - Hidden bit clear: shift left 1, exp − 1. If exp reaches 0 while still unnormalised, set unf and result = +0, then go to DONE.
  - Go to DONE once the hidden bit is set and there is no carry.
- DONE:
  - out_valid = 1. result, ovf and unf are held stable until out_ready.
  - On handshake, go to IDLE; out_valid = 0 and in_ready = 1 from the next cycle.
  - ovf/unf are valid only with out_valid.
- Latency (accept cycle = 0): out_valid first high in cycle 2 + cnt + nshift. Zero-operand shortcut: cycle 1.
- Throughput: one operation in flight. in_ready = 0 in every non-IDLE state.
- in_valid while busy is ignored; the source must hold it until in_ready.

Optional Feature:
- FP_RNE_ROUND_EN defined:
  - ALIGN keeps guard, round and sticky bits (sticky = OR of all bits shifted out).
  - After NORM, round to nearest, ties to even.
  - A rounding carry re-enters NORM for one right shift, which may set ovf.
  - Latency grows by 1 cycle (a ROUND state between NORM and DONE).
- Undefined: truncation; no ROUND state.

Decomposition:
- Package fp_seq_pkg:
  - state_t enum.
  - Packed struct fp_t {sign, exp, mant}.
  - EXP_MAX, MANT_ONES, BIAS localparams.
  - Helper function is_zero().
- Sub-module exp_compare:
  - Combinational.
  - Outputs diff magnitude, a_bigger, bigger/smaller exponent.
  - Instantiated once in IDLE-accept logic.

Test Plan (format s|eee|mmmm, BIAS=3, default truncation):
- 0x30 + 0x30 (1.0 + 1.0) -> result 0x40, out_valid in cycle 3 (diff 0, one right shift), ovf = unf = 0.
- 0x38 + 0x20 (1.5 + 0.5) -> 0x40. One ALIGN cycle, one NORM shift, out_valid in cycle 4.
- 0x38 − 0x38 -> +0 (0x00), no flags. Also 0x00 + 0xB0 -> 0xB0 in cycle 1 (zero shortcut).
- 0x7F + 0x7F -> ovf = 1, result 0x7F. Then 0x11 − 0x10 -> unf = 1, result 0x00.
- Backpressure: hold out_ready low 5 cycles after out_valid -> result/flags stable, in_ready = 0, in_valid pulses ignored. Release -> in_ready = 1 next cycle.
- Pull rst_n low in ALIGN with diff 4 -> next cycle out_valid = 0, in_ready = 1, busy = 0. The next op 0x30 + 0x30 still returns 0x40.
